axi_line_drawer_regs: RTL and testbench

- AXI4-Lite slave register file: the responder end of the S00_AXI interface that the master VIP drives.
- Holds line endpoints and colour for the line-drawing engine, and issues a one-cycle start pulse to the engine.
- Exposes engine status (busy, sticky done) for polling.
- Sits between the PS/VIP AXI master and the raster core inside axi_line_drawer.

---
 rtl/axi_line_drawer_pkg.sv | 37 +++
 rtl/axi_line_drawer_regs.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_line_drawer_regs.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_line_drawer_pkg.sv
// Shared constants for the line-drawer AXI4-Lite register file: word offsets,
// response codes, STATUS bit positions and the byte-strobe merge helper.
package axi_line_drawer_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    // Word indices (byte address [4:2])
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_P0     = 3'd1;
    localparam logic [2:0] REG_P1     = 3'd2;
    localparam logic [2:0] REG_COLOUR = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] result;
        for (int b = 0; b < STRB_W; b++) begin
            result[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return result;
    endfunction

    function automatic logic is_mapped(input logic [2:0] idx);
        return idx <= REG_STATUS;
    endfunction

endpackage

// File: rtl/axi_line_drawer_regs.sv
// AXI4-Lite slave holding line endpoints/colour for the raster core, with a
// start pulse on CTRL bit0 and a pollable busy / sticky-done STATUS word.
module axi_line_drawer_regs
    import axi_line_drawer_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [15:0]                       x0_o,
    output logic [15:0]                       y0_o,
    output logic [15:0]                       x1_o,
    output logic [15:0]                       y1_o,
    output logic [31:0]                       colour_o,
    output logic                              start_o,
    input  logic                              busy_i,
    input  logic                              done_i
);

    // Keeps every READY low while reset is asserted and for the first edge after.
    logic        ready_en_q;

    logic        aw_held_q, aw_held_d;
    logic [4:0]  aw_addr_q, aw_addr_d;
    logic        w_held_q, w_held_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] p0_q, p0_d;
    logic [31:0] p1_q, p1_d;
    logic [31:0] colour_q, colour_d;
    logic        done_q, done_d;
    logic        start_q, start_d;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [2:0]  wr_idx;
    logic [2:0]  rd_idx;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = ready_en_q && !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = ready_en_q && !w_held_q && !bvalid_q;
    assign S_AXI_ARREADY = ready_en_q && !rvalid_q;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;

    // A held beat takes priority; otherwise the beat handshaking this cycle is used.
    assign wr_addr = aw_held_q ? aw_addr_q : S_AXI_AWADDR[4:0];
    assign wr_data = w_held_q ? w_data_q : S_AXI_WDATA[31:0];
    assign wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB[3:0];
    assign wr_idx  = wr_addr[4:2];
    assign rd_idx  = S_AXI_ARADDR[4:2];

    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        p0_d      = p0_q;
        p1_d      = p1_q;
        colour_d  = colour_q;
        done_d    = done_q;
        start_d   = 1'b0;

        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = is_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
            case (wr_idx)
                REG_CTRL: begin
                    ctrl_d  = apply_wstrb(ctrl_q, wr_data, wr_strb);
                    start_d = ctrl_d[0] && !busy_i;
                end
                REG_P0:     p0_d     = apply_wstrb(p0_q, wr_data, wr_strb);
                REG_P1:     p1_d     = apply_wstrb(p1_q, wr_data, wr_strb);
                REG_COLOUR: colour_d = apply_wstrb(colour_q, wr_data, wr_strb);
                REG_STATUS: begin
                    if (wr_strb[0] && wr_data[STATUS_DONE_BIT]) begin
                        done_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_addr_d = S_AXI_AWADDR[4:0];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = S_AXI_WDATA[31:0];
                w_strb_d = S_AXI_WSTRB[3:0];
            end
        end

        // A completion in the same cycle as a W1C must not be lost.
        if (done_i) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = is_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
            case (rd_idx)
                REG_CTRL:   rdata_d = ctrl_q;
                REG_P0:     rdata_d = p0_q;
                REG_P1:     rdata_d = p1_q;
                REG_COLOUR: rdata_d = colour_q;
                REG_STATUS: begin
                    rdata_d                  = 32'd0;
                    rdata_d[STATUS_BUSY_BIT] = busy_i;
                    rdata_d[STATUS_DONE_BIT] = done_q;
                end
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            ctrl_q     <= '0;
            p0_q       <= '0;
            p1_q       <= '0;
            colour_q   <= '0;
            done_q     <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            aw_addr_q  <= aw_addr_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            ctrl_q     <= ctrl_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            colour_q   <= colour_d;
            done_q     <= done_d;
            start_q    <= start_d;
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;

    assign x0_o     = p0_q[15:0];
    assign y0_o     = p0_q[31:16];
    assign x1_o     = p1_q[15:0];
    assign y1_o     = p1_q[31:16];
    assign colour_o = colour_q;
    assign start_o  = start_q;

endmodule

// File: tb/tb_axi_line_drawer_regs.sv
// Directed bench for axi_line_drawer_regs: table of register transactions plus
// hand-written sequences for split AW/W, start pulse, W1C race, backpressure, reset.
module tb_axi_line_drawer_regs;
    import axi_line_drawer_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [15:0] x0_o, y0_o, x1_o, y1_o;
    logic [31:0] colour_o;
    logic        start_o;
    logic        busy_i;
    logic        done_i;

    int checks = 0;
    int failures = 0;
    int start_cycles = 0;

    always #5 ACLK = ~ACLK;

    axi_line_drawer_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .x0_o(x0_o), .y0_o(y0_o), .x1_o(x1_o), .y1_o(y1_o),
        .colour_o(colour_o), .start_o(start_o),
        .busy_i(busy_i), .done_i(done_i)
    );

    always @(negedge ACLK) begin
        if (start_o === 1'b1) start_cycles++;
    end

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit with_done,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_now, w_now;
        int n;
        aw_done = 0;
        w_done  = 0;
        resp    = 2'bxx;
        @(negedge ACLK);
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        if (with_done) done_i = 1'b1;
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
            w_now  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK);
            @(negedge ACLK);
            done_i = 1'b0;
            if (aw_now) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
            if (w_now)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
            n++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) begin
            timeout("wr_addr_data");
        end else begin
            n = 0;
            while (!S_AXI_BVALID && n < 20) begin
                @(negedge ACLK);
                n++;
            end
            if (!S_AXI_BVALID) timeout("wr_bvalid");
            else begin
                resp = S_AXI_BRESP;
                @(posedge ACLK);
                @(negedge ACLK);
            end
        end
        S_AXI_BREADY = 1'b0;
        $display("WR addr=0x%02h data=0x%08h strb=%b resp=%b", addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        data = 'x;
        resp = 2'bxx;
        @(negedge ACLK);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (!S_AXI_ARREADY) begin
            timeout("rd_arready");
        end else begin
            @(posedge ACLK);
            @(negedge ACLK);
            S_AXI_ARVALID = 1'b0;
            n = 0;
            while (!S_AXI_RVALID && n < 20) begin
                @(negedge ACLK);
                n++;
            end
            if (!S_AXI_RVALID) timeout("rd_rvalid");
            else begin
                data = S_AXI_RDATA;
                resp = S_AXI_RRESP;
                @(posedge ACLK);
                @(negedge ACLK);
            end
        end
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        $display("RD addr=0x%02h data=0x%08h resp=%b", addr, data, resp);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          base;

        vecs[0]  = '{1'b1, 5'h00, 32'd1,         4'hF, 32'd0,         RESP_OKAY};
        vecs[1]  = '{1'b1, 5'h04, 32'd2,         4'hF, 32'd0,         RESP_OKAY};
        vecs[2]  = '{1'b1, 5'h08, 32'd3,         4'hF, 32'd0,         RESP_OKAY};
        vecs[3]  = '{1'b1, 5'h0C, 32'd4,         4'hF, 32'd0,         RESP_OKAY};
        vecs[4]  = '{1'b0, 5'h00, 32'd0,         4'h0, 32'd1,         RESP_OKAY};
        vecs[5]  = '{1'b0, 5'h04, 32'd0,         4'h0, 32'd2,         RESP_OKAY};
        vecs[6]  = '{1'b0, 5'h08, 32'd0,         4'h0, 32'd3,         RESP_OKAY};
        vecs[7]  = '{1'b0, 5'h0C, 32'd0,         4'h0, 32'd4,         RESP_OKAY};
        vecs[8]  = '{1'b1, 5'h18, 32'hDEADBEEF,  4'hF, 32'd0,         RESP_SLVERR};
        vecs[9]  = '{1'b0, 5'h1C, 32'd0,         4'h0, 32'd0,         RESP_SLVERR};
        vecs[10] = '{1'b0, 5'h14, 32'd0,         4'h0, 32'd0,         RESP_SLVERR};
        vecs[11] = '{1'b0, 5'h10, 32'd0,         4'h0, 32'd0,         RESP_OKAY};
        vecs[12] = '{1'b1, 5'h04, 32'hAABBCCDD,  4'b0101, 32'd0,      RESP_OKAY};
        vecs[13] = '{1'b0, 5'h04, 32'd0,         4'h0, 32'h00BB00DD,  RESP_OKAY};
        vecs[14] = '{1'b1, 5'h08, 32'hFFFFFFFF,  4'h0, 32'd0,         RESP_OKAY};
        vecs[15] = '{1'b0, 5'h08, 32'd0,         4'h0, 32'd3,         RESP_OKAY};
        vecs[16] = '{1'b0, 5'h00, 32'd0,         4'h0, 32'd1,         RESP_OKAY};

        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        busy_i = 1'b0;
        done_i = 1'b0;

        repeat (3) @(negedge ACLK);
        check("rst_awready", S_AXI_AWREADY, 0);
        check("rst_arready", S_AXI_ARREADY, 0);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_start", start_o, 0);
        check("rst_colour", colour_o, 0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        // Table-driven register accesses
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0, rsp);
                check($sformatf("vec%0d_bresp", i), rsp, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, rd, rsp);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), rsp, vecs[i].exp_resp);
            end
            if (i == 7) begin
                check("x0_after_writes", x0_o, 16'd2);
                check("colour_after_writes", colour_o, 32'd4);
            end
        end

        // W three cycles ahead of AW
        @(negedge ACLK);
        S_AXI_WDATA = 32'h00200010; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b0;
        check("split_wready", S_AXI_WREADY, 1);
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_WVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("split_no_bvalid%0d", c), S_AXI_BVALID, 0);
            @(negedge ACLK);
        end
        check("split_wready_held", S_AXI_WREADY, 0);
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
        check("split_awready", S_AXI_AWREADY, 1);
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        check("split_bvalid", S_AXI_BVALID, 1);
        check("split_bresp", S_AXI_BRESP, RESP_OKAY);
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        check("split_bvalid_clr", S_AXI_BVALID, 0);
        check("split_x0", x0_o, 16'h0010);
        check("split_y0", y0_o, 16'h0020);
        $display("WR split addr=0x04 data=0x00200010");

        // Start pulse, then suppressed while busy
        base = start_cycles;
        axi_write(5'h00, 32'h1, 4'hF, 1'b0, rsp);
        repeat (2) @(negedge ACLK);
        check("start_pulse_cycles", start_cycles - base, 1);
        busy_i = 1'b1;
        base = start_cycles;
        axi_write(5'h00, 32'h1, 4'hF, 1'b0, rsp);
        repeat (2) @(negedge ACLK);
        check("start_busy_cycles", start_cycles - base, 0);
        axi_read(5'h00, rd, rsp);
        check("ctrl_busy_write", rd, 32'h1);
        busy_i = 1'b0;

        // Sticky done and W1C race
        @(negedge ACLK); done_i = 1'b1;
        @(negedge ACLK); done_i = 1'b0;
        axi_read(5'h10, rd, rsp);
        check("status_done", rd, 32'h2);
        busy_i = 1'b1;
        axi_read(5'h10, rd, rsp);
        check("status_busy_done", rd, 32'h3);
        busy_i = 1'b0;
        axi_write(5'h10, 32'h2, 4'hF, 1'b1, rsp);
        check("w1c_race_bresp", rsp, RESP_OKAY);
        axi_read(5'h10, rd, rsp);
        check("status_race_set_wins", rd, 32'h2);
        axi_write(5'h10, 32'h2, 4'hF, 1'b0, rsp);
        axi_read(5'h10, rd, rsp);
        check("status_cleared", rd, 32'h0);

        // Write response backpressure
        @(negedge ACLK);
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h00070006; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_bvalid%0d", c), S_AXI_BVALID, 1);
            check($sformatf("bp_bresp%0d", c), S_AXI_BRESP, RESP_OKAY);
            check($sformatf("bp_awready%0d", c), S_AXI_AWREADY, 0);
            @(negedge ACLK);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        check("bp_bvalid_clr", S_AXI_BVALID, 0);
        check("bp_x1", x1_o, 16'h0006);
        check("bp_y1", y1_o, 16'h0007);
        $display("WR backpressure addr=0x08 data=0x00070006");

        // Read data backpressure
        S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        S_AXI_ARADDR = 5'h1C;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_rvalid%0d", c), S_AXI_RVALID, 1);
            check($sformatf("bp_rdata%0d", c), S_AXI_RDATA, 32'h00070006);
            check($sformatf("bp_arready%0d", c), S_AXI_ARREADY, 0);
            @(negedge ACLK);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        check("bp_rvalid_clr", S_AXI_RVALID, 0);
        $display("RD backpressure addr=0x08 data=0x00070006");

        // Reset with responses pending on both channels
        S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("pre_rst_bvalid", S_AXI_BVALID, 1);
        check("pre_rst_rvalid", S_AXI_RVALID, 1);
        check("pre_rst_colour", colour_o, 32'h55);
        #2 ARESETN = 1'b0;
        #1;
        check("mid_rst_bvalid", S_AXI_BVALID, 0);
        check("mid_rst_rvalid", S_AXI_RVALID, 0);
        check("mid_rst_colour", colour_o, 0);
        check("mid_rst_x0", x0_o, 0);
        check("mid_rst_awready", S_AXI_AWREADY, 0);
        check("mid_rst_rdata", S_AXI_RDATA, 0);
        $display("RST asserted mid-transaction");
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        check("post_rst_no_bvalid", S_AXI_BVALID, 0);
        axi_read(5'h0C, rd, rsp);
        check("post_rst_colour_rd", rd, 32'h0);
        axi_read(5'h00, rd, rsp);
        check("post_rst_ctrl_rd", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
